// File: rtl/matmul_job_sched_if.sv
// Host command, controller and hash-engine signals of the matmul job scheduler.
interface matmul_job_sched_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_mode;
    logic [9:0] cmd_blocks;
    logic [2:0] mem_mode;
    logic       calc_init;
    logic [3:0] ctrl_state;
    logic       HASH_ready;
    logic       hash_req;
    logic       hash_ack;
    logic       busy;
    logic       done;
    logic       done_status;
    logic       err_illegal;

    // Environment side: host, memory controller and hash engine
    modport master (
        output cmd_valid, cmd_mode, cmd_blocks, ctrl_state, hash_ack,
        input  cmd_ready, mem_mode, calc_init, HASH_ready, hash_req,
               busy, done, done_status, err_illegal
    );

    // Scheduler side
    modport slave (
        input  cmd_valid, cmd_mode, cmd_blocks, ctrl_state, hash_ack,
        output cmd_ready, mem_mode, calc_init, HASH_ready, hash_req,
               busy, done, done_status, err_illegal
    );
endinterface

// File: rtl/matmul_job_sched.sv
// Job scheduler in front of the systolic-array memory controller: queues
// host jobs, launches them, and services the controller's hash-wait state.
module matmul_job_sched #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [3:0]  WAIT_AS_CODE = 4'd3,
    parameter logic [3:0]  WAIT_SA_CODE = 4'd7,
    parameter int unsigned HASH_TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst_n,
    matmul_job_sched_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TO_W  = $clog2(HASH_TIMEOUT);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(HASH_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_RUN, S_HASH, S_REL, S_DONE
    } state_t;

    state_t            state, state_nx;
    logic [2:0]        q_mode   [FIFO_DEPTH];
    logic [9:0]        q_blocks [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, wr_ptr_nx, rd_ptr, rd_ptr_nx;
    logic [CNT_W-1:0]  count, count_nx;
    logic [9:0]        job_blocks, job_blocks_nx;
    logic [9:0]        block_cnt, block_cnt_nx;
    logic [TO_W-1:0]   to_cnt, to_cnt_nx;
    logic [3:0]        ctrl_prev, wait_code;
    logic              legal, push, pop, wait_entry;
    logic              cmd_ready_q, cmd_ready_nx;
    logic [2:0]        mem_mode_q, mem_mode_nx;
    logic              calc_init_q, calc_init_nx, hash_ready_q, hash_ready_nx;
    logic              hash_req_q, hash_req_nx, busy_q, busy_nx;
    logic              done_q, done_nx, status_q, status_nx, err_q, err_nx;

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.mem_mode    = mem_mode_q;
    assign bus.calc_init   = calc_init_q;
    assign bus.HASH_ready  = hash_ready_q;
    assign bus.hash_req    = hash_req_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.done_status = status_q;
    assign bus.err_illegal = err_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state, queue bookkeeping and next values of the registered outputs
    always_comb begin
        state_nx      = state;
        job_blocks_nx = job_blocks;
        block_cnt_nx  = block_cnt;
        to_cnt_nx     = to_cnt;
        mem_mode_nx   = mem_mode_q;
        status_nx     = 1'b0;
        pop           = 1'b0;
        legal         = (bus.cmd_mode >= 3'd1) && (bus.cmd_mode <= 3'd4) &&
                        (bus.cmd_blocks != 10'd0);
        push          = bus.cmd_valid && cmd_ready_q && legal;
        err_nx        = bus.cmd_valid && cmd_ready_q && !legal;
        wait_code     = (mem_mode_q == 3'd1 || mem_mode_q == 3'd3) ? WAIT_AS_CODE
                                                                  : WAIT_SA_CODE;
        wait_entry    = (bus.ctrl_state == wait_code) && (ctrl_prev != wait_code);

        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    pop           = 1'b1;
                    mem_mode_nx   = q_mode[rd_ptr];
                    job_blocks_nx = q_blocks[rd_ptr];
                    state_nx      = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                block_cnt_nx = '0;
                state_nx     = S_RUN;
            end
            S_RUN: begin
                if (wait_entry) begin
                    if (({1'b0, block_cnt} + 11'd1) == {1'b0, job_blocks}) begin
                        state_nx = S_DONE;
                    end else begin
                        block_cnt_nx = block_cnt + 10'd1;
                        to_cnt_nx    = '0;
                        state_nx     = S_HASH;
                    end
                end
            end
            S_HASH: begin
                // An ack on the last allowed cycle still counts as an ack
                if (bus.hash_ack) begin
                    state_nx = S_REL;
                end else if (to_cnt == TO_LAST) begin
                    status_nx = 1'b1;
                    state_nx  = S_DONE;
                end else begin
                    to_cnt_nx = to_cnt + TO_W'(1);
                end
            end
            S_REL:   state_nx = S_RUN;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase

        wr_ptr_nx     = push ? wr_ptr + PTR_W'(1) : wr_ptr;
        rd_ptr_nx     = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_nx      = count + CNT_W'(push) - CNT_W'(pop);
        cmd_ready_nx  = (count_nx != CNT_FULL);
        calc_init_nx  = (state_nx == S_LAUNCH);
        hash_req_nx   = (state_nx == S_HASH);
        hash_ready_nx = (state_nx == S_REL);
        done_nx       = (state_nx == S_DONE);
        busy_nx       = (state_nx != S_IDLE);
    end

    // Queue pointers, job registers, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            job_blocks   <= '0;
            block_cnt    <= '0;
            to_cnt       <= '0;
            ctrl_prev    <= '0;
            cmd_ready_q  <= 1'b1;
            mem_mode_q   <= '0;
            calc_init_q  <= 1'b0;
            hash_ready_q <= 1'b0;
            hash_req_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            status_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_nx;
            rd_ptr       <= rd_ptr_nx;
            count        <= count_nx;
            job_blocks   <= job_blocks_nx;
            block_cnt    <= block_cnt_nx;
            to_cnt       <= to_cnt_nx;
            ctrl_prev    <= bus.ctrl_state;
            cmd_ready_q  <= cmd_ready_nx;
            mem_mode_q   <= mem_mode_nx;
            calc_init_q  <= calc_init_nx;
            hash_ready_q <= hash_ready_nx;
            hash_req_q   <= hash_req_nx;
            busy_q       <= busy_nx;
            done_q       <= done_nx;
            status_q     <= status_nx;
            err_q        <= err_nx;
        end
    end

    // Command queue storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) begin
            q_mode[wr_ptr]   <= bus.cmd_mode;
            q_blocks[wr_ptr] <= bus.cmd_blocks;
        end
    end
endmodule

// File: tb/tb_matmul_job_sched.sv
// Randomized self-checking bench for matmul_job_sched: the bench plays host,
// memory controller and hash engine, and predicts behaviour from a job queue model.
module tb_matmul_job_sched;
    localparam int unsigned TB_TIMEOUT = 16;
    localparam int POL_RAND = 0, POL_NOM = 1, POL_DWELL = 2, POL_TIMEOUT = 3,
                   POL_EDGE = 4, POL_SLOW = 5;
    localparam int RN = 16;

    typedef struct {
        logic [2:0] mode;
        logic [9:0] blocks;
    } job_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    matmul_job_sched_if bus();

    matmul_job_sched #(
        .FIFO_DEPTH(4), .WAIT_AS_CODE(4'd3), .WAIT_SA_CODE(4'd7),
        .HASH_TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int n_calc = 0, n_done = 0, n_hr = 0, n_err = 0;
    int exp_launch = 0, exp_err = 0, exp_hr = 0, aborted = 0;
    job_t exp_q[$];

    // Pulse counters, sampled mid-cycle while out of reset
    always @(negedge clk) begin
        if (rst_n) begin
            n_calc = n_calc + 32'(bus.calc_init);
            n_done = n_done + 32'(bus.done);
            n_hr   = n_hr + 32'(bus.HASH_ready);
            n_err  = n_err + 32'(bus.err_illegal);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] out_vec();
        return {bus.cmd_ready, bus.mem_mode, bus.calc_init, bus.HASH_ready, bus.hash_req,
                bus.busy, bus.done, bus.done_status, bus.err_illegal};
    endfunction

    function automatic logic [3:0] nonwait(input logic [3:0] wcode);
        logic [3:0] v;
        v = 4'($urandom_range(0, 15));
        if (v == wcode) v = v ^ 4'd1;
        return v;
    endfunction

    // Host: hold a command until the queue takes it, then update the model
    task automatic send(input logic [2:0] mode, input logic [9:0] blocks);
        int n;
        logic rdy;
        job_t j;
        n = 0;
        bus.cmd_valid  = 1'b1;
        bus.cmd_mode   = mode;
        bus.cmd_blocks = blocks;
        do begin
            rdy = bus.cmd_ready;
            step();
            n++;
        end while (!rdy && n < 500);
        bus.cmd_valid = 1'b0;
        check("cmd_accept", 32'(rdy), 1);
        if (mode >= 3'd1 && mode <= 3'd4 && blocks != 10'd0) begin
            j.mode = mode;
            j.blocks = blocks;
            exp_q.push_back(j);
            exp_launch++;
        end else begin
            exp_err++;
            check("err_pulse", 32'(bus.err_illegal), 1);
        end
    endtask

    task automatic wait_calc_init(output int lat);
        lat = 0;
        while (!bus.calc_init && lat < 3000) begin
            step();
            lat++;
        end
        check("calc_init_seen", 32'(bus.calc_init), 1);
    endtask

    // Controller + hash engine for one launched job; entered on the calc_init cycle
    task automatic serve_job(input logic [2:0] mode, input int blocks, input int policy);
        logic [3:0] wcode;
        int n, d, dwell, r;
        wcode = (mode == 3'd1 || mode == 3'd3) ? 4'd3 : 4'd7;
        check("launch_mode", 32'(bus.mem_mode), 32'(mode));
        check("launch_busy", 32'(bus.busy), 1);
        for (int k = 1; k <= blocks; k++) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) begin
                bus.ctrl_state = nonwait(wcode);
                step();
                if (k == 1 && i == 0) check("calc_init_pulse", 32'(bus.calc_init), 0);
            end
            bus.ctrl_state = wcode;
            step();
            if (k == blocks) begin
                check("final_done", 32'(bus.done), 1);
                check("final_status", 32'(bus.done_status), 0);
                check("final_no_req", 32'(bus.hash_req), 0);
            end else begin
                check("req_up", 32'(bus.hash_req), 1);
                check("req_no_done", 32'(bus.done), 0);
                d = $urandom_range(0, 3);
                dwell = 0;
                case (policy)
                    POL_RAND: begin
                        r = $urandom_range(0, 11);
                        if (r == 0) d = -1;
                        else if (r == 1) d = TB_TIMEOUT - 1;
                        if ($urandom_range(0, 3) == 0) dwell = 20;
                    end
                    POL_DWELL:   dwell = 20;
                    POL_TIMEOUT: d = -1;
                    POL_EDGE:    d = TB_TIMEOUT - 1;
                    POL_SLOW:    d = 8;
                    default:     ;
                endcase
                if (d < 0) begin
                    n = 0;
                    while (bus.hash_req && n < 40) begin
                        n++;
                        step();
                    end
                    check("timeout_req_len", n, TB_TIMEOUT);
                    check("timeout_done", 32'(bus.done), 1);
                    check("timeout_status", 32'(bus.done_status), 1);
                    break;
                end
                for (int i = 0; i < d; i++) step();
                check("req_held", 32'(bus.hash_req), 1);
                bus.hash_ack = 1'b1;
                step();
                bus.hash_ack = 1'b0;
                exp_hr++;
                check("req_drop", 32'(bus.hash_req), 0);
                check("hash_ready", 32'(bus.HASH_ready), 1);
                check("ack_no_done", 32'(bus.done), 0);
                for (int i = 0; i < dwell; i++) begin
                    step();
                    check("dwell_quiet", 32'({bus.hash_req, bus.HASH_ready, bus.done}), 0);
                end
            end
        end
        step();
        check("busy_clear", 32'(bus.busy), 0);
        check("done_single", 32'(bus.done), 0);
    endtask

    task automatic serve_next(input int policy, output int lat);
        job_t j;
        wait_calc_init(lat);
        if (!bus.calc_init) return;
        if (exp_q.size() == 0) begin
            check("spurious_launch", 32'(bus.calc_init), 0);
            return;
        end
        j = exp_q.pop_front();
        serve_job(j.mode, int'(j.blocks), policy);
    endtask

    initial begin
        int lat, legal_cnt, b_calc, b_done, v;
        logic [2:0] qm[5];
        logic [9:0] qb[5];
        logic [2:0] cm[RN];
        logic [9:0] cb[RN];
        job_t jr;

        bus.cmd_valid = 1'b0; bus.cmd_mode = '0; bus.cmd_blocks = '0;
        bus.ctrl_state = '0;  bus.hash_ack = 1'b0;
        repeat (3) step();
        check("reset_outputs", 32'(out_vec()), 32'h400);
        rst_n = 1'b1;
        step();
        check("idle_outputs", 32'(out_vec()), 32'h400);

        // AS job, 2 blocks: launch latency, one hash round, then done
        send(3'd1, 10'd2);
        check("calc_init_early", 32'(bus.calc_init), 0);
        step();
        check("calc_init_latency", 32'(bus.calc_init), 1);
        serve_next(POL_NOM, lat);
        repeat (3) step();
        check("mem_mode_hold", 32'(bus.mem_mode), 1);

        // Illegal commands are dropped
        b_calc = n_calc;
        v = n_err;
        send(3'd0, 10'd5);
        send(3'd5, 10'd5);
        send(3'd1, 10'd0);
        repeat (5) step();
        check("illegal_err_count", n_err - v, 3);
        check("illegal_no_launch", n_calc - b_calc, 0);
        check("illegal_idle", 32'(bus.busy), 0);

        // SA job with long wait-state dwell, SB timeout, BS ack on the timeout cycle
        send(3'd2, 10'd3);
        serve_next(POL_DWELL, lat);
        send(3'd3, 10'd2);
        serve_next(POL_TIMEOUT, lat);
        send(3'd4, 10'd2);
        serve_next(POL_EDGE, lat);

        // Fill the queue behind a running job; jobs run in order, back to back
        qm[0] = 3'd2; qm[1] = 3'd3; qm[2] = 3'd4; qm[3] = 3'd1; qm[4] = 3'd2;
        for (int i = 0; i < 5; i++) qb[i] = 10'($urandom_range(1, 3));
        send(3'd1, 10'd3);
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    send(qm[i], qb[i]);
                    if (i == 3) check("queue_full_ready", 32'(bus.cmd_ready), 0);
                end
            end
            begin
                serve_next(POL_SLOW, lat);
                for (int i = 0; i < 5; i++) begin
                    serve_next(POL_NOM, lat);
                    check("b2b_gap", lat, 1);
                end
            end
        join

        // Reset while waiting on the hash engine with two jobs queued
        send(3'd2, 10'd3);
        wait_calc_init(lat);
        jr = exp_q.pop_front();
        bus.ctrl_state = 4'd0;
        step();
        bus.ctrl_state = 4'd7;
        step();
        check("pre_reset_req", 32'(bus.hash_req), 1);
        send(3'd1, 10'd1);
        send(3'd3, 10'd2);
        b_calc = n_calc;
        b_done = n_done;
        rst_n = 1'b0;
        #1;
        check("reset_mid_outputs", 32'(out_vec()), 32'h400);
        exp_launch = exp_launch - exp_q.size();
        exp_q.delete();
        aborted++;
        repeat (2) step();
        rst_n = 1'b1;
        bus.ctrl_state = 4'd0;
        repeat (10) step();
        check("reset_no_launch", n_calc - b_calc, 0);
        check("reset_no_done", n_done - b_done, 0);
        check("reset_ready", 32'(bus.cmd_ready), 1);
        send(3'd3, 10'd2);
        serve_next(POL_NOM, lat);

        // Random traffic with legal and illegal commands
        legal_cnt = 0;
        for (int i = 0; i < RN; i++) begin
            v = $urandom_range(0, 5);
            cm[i] = 3'($urandom_range(1, 4));
            cb[i] = 10'($urandom_range(1, 4));
            if (v == 0) begin
                v = $urandom_range(0, 3);
                cm[i] = (v == 0) ? 3'd0 : 3'(v + 4);
            end else if (v == 1) begin
                cb[i] = 10'd0;
            end else begin
                legal_cnt++;
            end
        end
        fork
            begin
                for (int i = 0; i < RN; i++) begin
                    repeat ($urandom_range(0, 4)) step();
                    send(cm[i], cb[i]);
                end
            end
            begin
                for (int i = 0; i < legal_cnt; i++) serve_next(POL_RAND, lat);
            end
        join
        repeat (5) step();

        check("total_launch", n_calc, exp_launch);
        check("total_done", n_done, exp_launch - aborted);
        check("total_hash_ready", n_hr, exp_hr);
        check("total_err", n_err, exp_err);
        check("end_idle", 32'(bus.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
